// File: rtl/matrix_fetch_unpack_pkg.sv
// Shared constants, state encoding and address helper for the matrix fetch/unpack loader.
// No ports.
package matrix_fetch_unpack_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int NUM_ROWS       = 8;
    localparam int WORD_W         = 64;
    localparam int ELEMS_PER_WORD = WORD_W / DATA_WIDTH;
    localparam int ADDR_W         = 32;
    localparam int IDX_W          = $clog2(ELEMS_PER_WORD);
    localparam int WORD_CNT_W     = $clog2(NUM_ROWS + 1);

    localparam logic [ADDR_W-1:0] B_ADDR      = '0;
    localparam logic [ADDR_W-1:0] A_BASE_ADDR = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        UNPACK,
        DONE
    } fetch_state_t;

    // Word 0 is the B vector; word k>0 is A row k-1.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_CNT_W-1:0] w);
        if (w == '0) begin
            return B_ADDR;
        end
        return A_BASE_ADDR + ADDR_W'(w) - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/matrix_fetch_unpack_if.sv
// Bus bundle for the loader: Avalon-MM read master signals plus the shared
// byte bus and write strobes / full flags of the B and A FIFOs.
//   master : loader side (drives address/read/fifo_*; sees readdata/flags)
//   slave  : memory + FIFO side
interface matrix_fetch_unpack_if;
    import matrix_fetch_unpack_pkg::*;

    logic [ADDR_W-1:0]     address;
    logic                  read;
    logic [WORD_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_wr_b;
    logic [NUM_ROWS-1:0]   fifo_wr_a;
    logic                  fifo_full_b;
    logic [NUM_ROWS-1:0]   fifo_full_a;

    modport master (
        output address, read, fifo_data, fifo_wr_b, fifo_wr_a,
        input  readdata, readdatavalid, waitrequest, fifo_full_b, fifo_full_a
    );

    modport slave (
        input  address, read, fifo_data, fifo_wr_b, fifo_wr_a,
        output readdata, readdatavalid, waitrequest, fifo_full_b, fifo_full_a
    );

endinterface

// File: rtl/matrix_fetch_unpack_word_unpacker.sv
// Holds one 64b word and presents its elements one at a time, element 0
// (most significant byte) first.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data, rewind index to element 0
//   load_data  : word to unpack
//   advance    : current element consumed, step to the next
//   byte_o     : current element
//   last       : current element is the final one of the word
module matrix_fetch_unpack_word_unpacker
    import matrix_fetch_unpack_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     load_data,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] byte_o,
    output logic                  last
);

    logic [WORD_W-1:0]     data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] elems [ELEMS_PER_WORD];

    for (genvar i = 0; i < ELEMS_PER_WORD; i++) begin : g_elem
        assign elems[i] = data_q[WORD_W-1-DATA_WIDTH*i -: DATA_WIDTH];
    end

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = load_data;
            idx_d  = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign byte_o = elems[idx_q];
    assign last   = (idx_q == IDX_W'(ELEMS_PER_WORD - 1));

endmodule

// File: rtl/matrix_fetch_unpack.sv
// Loader for the 8x8 matrix-vector MAC array: fetches the B vector word and
// NUM_ROWS A-row words over Avalon-MM and writes their bytes into the B FIFO
// and the matching A-row FIFOs, then pulses done.
//   clk, rst : clock, synchronous active-high reset
//   start    : request a load (ignored while busy and in the done cycle)
//   busy     : load in progress
//   done     : one-cycle pulse after the last byte strobe
//   bus      : Avalon read master + FIFO write side (master modport)
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | read asserted, address stable until waitrequest low
// RESP   | waiting for readdatavalid of the single outstanding read
// UNPACK | one byte per cycle into target FIFO, stalls while it is full
// DONE   | all words written, done pulse follows
module matrix_fetch_unpack
    import matrix_fetch_unpack_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    matrix_fetch_unpack_if.master bus
);

    fetch_state_t          state_q, state_d;
    logic [WORD_CNT_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic                  read_q, read_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                  fifo_wr_b_q, fifo_wr_b_d;
    logic [NUM_ROWS-1:0]   fifo_wr_a_q, fifo_wr_a_d;

    logic                  unpack_load;
    logic                  unpack_advance;
    logic                  unpack_last;
    logic [DATA_WIDTH-1:0] unpack_byte;

    logic                  sel_b;
    logic [NUM_ROWS-1:0]   row_sel;
    logic                  tgt_full;

    matrix_fetch_unpack_word_unpacker u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (unpack_load),
        .load_data (bus.readdata),
        .advance   (unpack_advance),
        .byte_o    (unpack_byte),
        .last      (unpack_last)
    );

    // Target FIFO decode from the word counter.
    always_comb begin
        sel_b   = (word_q == '0);
        row_sel = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_sel[r] = (word_q == WORD_CNT_W'(r + 1));
        end
        tgt_full = sel_b ? bus.fifo_full_b : |(row_sel & bus.fifo_full_a);
    end

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        address_d      = address_q;
        done_d         = 1'b0;
        fifo_data_d    = fifo_data_q;
        fifo_wr_b_d    = 1'b0;
        fifo_wr_a_d    = '0;
        unpack_load    = 1'b0;
        unpack_advance = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q blocks a start that arrives in the done cycle.
                if (start && !done_q) begin
                    word_d    = '0;
                    address_d = word_addr('0);
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (!bus.waitrequest) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.readdatavalid) begin
                    unpack_load = 1'b1;
                    state_d     = UNPACK;
                end
            end
            UNPACK: begin
                // A full target leaves strobes low and the element index
                // untouched, so the same byte is offered again next cycle.
                if (!tgt_full) begin
                    unpack_advance = 1'b1;
                    fifo_data_d    = unpack_byte;
                    fifo_wr_b_d    = sel_b;
                    fifo_wr_a_d    = row_sel;
                    if (unpack_last) begin
                        if (word_q == WORD_CNT_W'(NUM_ROWS)) begin
                            state_d = DONE;
                        end else begin
                            word_d    = word_q + 1'b1;
                            address_d = word_addr(word_d);
                            state_d   = REQ;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        read_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            address_q   <= '0;
            read_q      <= 1'b0;
            done_q      <= 1'b0;
            fifo_data_q <= '0;
            fifo_wr_b_q <= 1'b0;
            fifo_wr_a_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            address_q   <= address_d;
            read_q      <= read_d;
            done_q      <= done_d;
            fifo_data_q <= fifo_data_d;
            fifo_wr_b_q <= fifo_wr_b_d;
            fifo_wr_a_q <= fifo_wr_a_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign bus.address   = address_q;
    assign bus.read      = read_q;
    assign bus.fifo_data = fifo_data_q;
    assign bus.fifo_wr_b = fifo_wr_b_q;
    assign bus.fifo_wr_a = fifo_wr_a_q;

endmodule
